// File: rtl/pe_stream_scheduler.sv
// Per-PE stream sequencer. It walks the enabled channels, issues input and
// filter stream requests in the per-channel dataflow order, and then issues
// one PPU request. It reports done at layer end and keeps a sticky error flag
// for finish pulses that do not match the outstanding request.
module pe_stream_scheduler #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 10,
   parameter int KG_W   = 4,
   parameter int NUM_PE = 4,
   parameter int PE_ID  = 0,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    start_i,
   input  logic [NUM_CH-1:0]       cfg_valid_ch_i,
   input  logic [NUM_CH-1:0]       cfg_df_mode_i,
   input  logic [KG_W-1:0]         cfg_k_groups_i,
   input  logic [CNT_W-1:0]        cfg_weight_len_i,
   input  logic [NUM_CH*CNT_W-1:0] cfg_data_len_i,
   output logic                    req_valid_o,
   input  logic                    req_ready_i,
   output logic [1:0]              req_type_o,
   output logic [PE_W-1:0]         req_pe_o,
   output logic [CH_W-1:0]         req_ch_o,
   output logic [KG_W-1:0]         req_group_o,
   output logic [CNT_W-1:0]        req_len_o,
   input  logic                    input_finish_i,
   input  logic                    filter_finish_i,
   input  logic                    ppu_finish_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o
);

   // Request index within a channel: df=0 needs up to 1+K, df=1 up to 2K.
   localparam int RW = KG_W + 1;
   localparam logic [1:0] T_IN  = 2'd0;
   localparam logic [1:0] T_FLT = 2'd1;
   localparam logic [1:0] T_PPU = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_REQ, S_WAIT, S_PPU_REQ, S_PPU_WAIT, S_DONE
   } state_t;

   typedef struct packed {
      logic [1:0]       typ;
      logic [KG_W-1:0]  grp;
      logic [CNT_W-1:0] len;
   } req_f_t;

   state_t                         state_q;
   logic [NUM_CH-1:0]              vmask_q, df_q;
   logic [KG_W-1:0]                k_q;
   logic [CNT_W-1:0]               wlen_q;
   logic [NUM_CH-1:0][CNT_W-1:0]   dlen_q;
   logic [CH_W-1:0]                ch_q;
   logic [RW-1:0]                  r_q;
   logic                           req_valid_q, busy_q, done_q, err_q;
   logic [1:0]                     req_type_q;
   logic [CH_W-1:0]                req_ch_q;
   logic [KG_W-1:0]                req_group_q;
   logic [CNT_W-1:0]               req_len_q;

   logic                           found_d;
   logic [CH_W-1:0]                sel_ch_d, issue_ch_d;
   logic [RW-1:0]                  nreq_d, issue_r_d;
   logic                           last_d, fin_ok_d, bad_d;
   req_f_t                         nf_d;

   // Request fields for request index r of channel c, by dataflow order.
   function automatic req_f_t req_fields(input logic [CH_W-1:0] c, input logic [RW-1:0] r);
      req_f_t f;
      f.typ = T_FLT;
      f.len = wlen_q;
      if (!df_q[c]) begin
         f.grp = KG_W'(r - RW'(1));
         if (r == '0) begin
            f.typ = T_IN;
            f.grp = '0;
            f.len = dlen_q[c];
         end
      end else begin
         f.grp = KG_W'(r >> 1);
         if (r[0]) begin
            f.typ = T_IN;
            f.grp = '0;
            f.len = dlen_q[c];
         end
      end
      return f;
   endfunction

   // Lowest eligible channel at or above the current channel.
   always_comb begin
      found_d  = 1'b0;
      sel_ch_d = ch_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!found_d && i >= int'(ch_q) && vmask_q[i] && dlen_q[i] != '0) begin
            found_d  = 1'b1;
            sel_ch_d = CH_W'(i);
         end
      end
   end

   // Request count for the current channel and the fields of the next request.
   always_comb begin
      nreq_d     = df_q[ch_q] ? {k_q, 1'b0} : ({1'b0, k_q} + RW'(1));
      last_d     = (r_q == nreq_d - RW'(1));
      issue_ch_d = (state_q == S_SCAN) ? sel_ch_d : ch_q;
      issue_r_d  = (state_q == S_SCAN) ? '0 : r_q + RW'(1);
      nf_d       = req_fields(issue_ch_d, issue_r_d);
   end

   // Classify finish pulses against the outstanding request.
   always_comb begin
      fin_ok_d = 1'b0;
      bad_d    = input_finish_i | filter_finish_i | ppu_finish_i;
      if (state_q == S_WAIT) begin
         fin_ok_d = (req_type_q == T_IN) ? input_finish_i : filter_finish_i;
         bad_d    = ((req_type_q == T_IN) ? filter_finish_i : input_finish_i) | ppu_finish_i;
      end else if (state_q == S_PPU_WAIT) begin
         fin_ok_d = ppu_finish_i;
         bad_d    = input_finish_i | filter_finish_i;
      end
   end

   // Layer sequencer with registered request and status outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         vmask_q     <= '0;
         df_q        <= '0;
         k_q         <= '0;
         wlen_q      <= '0;
         dlen_q      <= '0;
         ch_q        <= '0;
         r_q         <= '0;
         req_valid_q <= 1'b0;
         req_type_q  <= '0;
         req_ch_q    <= '0;
         req_group_q <= '0;
         req_len_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: if (start_i) begin
               vmask_q <= cfg_valid_ch_i;
               df_q    <= cfg_df_mode_i;
               k_q     <= (cfg_k_groups_i == '0) ? KG_W'(1) : cfg_k_groups_i;
               wlen_q  <= cfg_weight_len_i;
               dlen_q  <= cfg_data_len_i;
               err_q   <= 1'b0;
               busy_q  <= 1'b1;
               ch_q    <= '0;
               r_q     <= '0;
               state_q <= S_SCAN;
            end
            S_SCAN: begin
               req_valid_q <= 1'b1;
               if (found_d) begin
                  ch_q        <= sel_ch_d;
                  r_q         <= '0;
                  req_type_q  <= nf_d.typ;
                  req_ch_q    <= sel_ch_d;
                  req_group_q <= nf_d.grp;
                  req_len_q   <= nf_d.len;
                  state_q     <= S_REQ;
               end else begin
                  req_type_q  <= T_PPU;
                  req_ch_q    <= '0;
                  req_group_q <= '0;
                  req_len_q   <= '0;
                  state_q     <= S_PPU_REQ;
               end
            end
            S_REQ: if (req_ready_i) begin
               req_valid_q <= 1'b0;
               state_q     <= S_WAIT;
            end
            S_WAIT: if (fin_ok_d) begin
               if (!last_d) begin
                  r_q         <= issue_r_d;
                  req_valid_q <= 1'b1;
                  req_type_q  <= nf_d.typ;
                  req_group_q <= nf_d.grp;
                  req_len_q   <= nf_d.len;
                  state_q     <= S_REQ;
               end else if (ch_q == CH_W'(NUM_CH - 1)) begin
                  req_valid_q <= 1'b1;
                  req_type_q  <= T_PPU;
                  req_ch_q    <= '0;
                  req_group_q <= '0;
                  req_len_q   <= '0;
                  state_q     <= S_PPU_REQ;
               end else begin
                  ch_q    <= ch_q + CH_W'(1);
                  state_q <= S_SCAN;
               end
            end
            S_PPU_REQ: if (req_ready_i) begin
               req_valid_q <= 1'b0;
               state_q     <= S_PPU_WAIT;
            end
            S_PPU_WAIT: if (fin_ok_d) begin
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
         // A stray finish wins over the clear from a same-cycle start.
         if (bad_d) err_q <= 1'b1;
      end
   end

   assign req_valid_o = req_valid_q;
   assign req_type_o  = req_type_q;
   assign req_pe_o    = PE_W'(PE_ID);
   assign req_ch_o    = req_ch_q;
   assign req_group_o = req_group_q;
   assign req_len_o   = req_len_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: doc/pe_stream_scheduler.md
Name: pe_stream_scheduler

Overview:
Per-PE sequencer that issues compressed input and filter stream requests channel by channel, then triggers the PPU. It supports a run-time dataflow mode per channel and a configurable number of filter groups. It sits between the global buffer stream engines and the PE multiplier array, and generalises the fixed-shape PE controller to NUM_CH channels, NUM_PE instances and two dataflow orders.

Parameters:
NUM_CH, 8, maximum input channels per layer
CNT_W, 10, width of stream length and boundary counters
KG_W, 4, width of filter-group count/index
NUM_PE, 4, number of PEs in the array (sizes PE_ID)
PE_ID, 0, index of this PE, echoed on requests

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latch config and begin layer (ignored unless IDLE)
cfg_valid_ch  in  NUM_CH  channel enable mask
cfg_df_mode  in  NUM_CH  per-channel dataflow: 0 input-stationary, 1 filter-stationary
cfg_k_groups  in  KG_W  filter groups per channel (0 treated as 1)
cfg_weight_len  in  CNT_W  compressed weight count per filter stream
cfg_data_len  in  NUM_CH*CNT_W  compressed input length per channel, ch0 in LSBs
req_valid  out  1  stream request valid
req_ready  in  1  stream engine accepts request
req_type  out  2  0 input, 1 filter, 2 PPU
req_pe  out  $clog2(NUM_PE)  always PE_ID
req_ch  out  $clog2(NUM_CH)  channel index
req_group  out  KG_W  filter group index (0 for input/PPU)
req_len  out  CNT_W  stream length (0 for PPU)
input_finish  in  1  pulse: input stream complete
filter_finish  in  1  pulse: filter stream complete
ppu_finish  in  1  pulse: PPU writeback complete
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at layer end
err  out  1  sticky: unexpected finish pulse; cleared by next accepted start

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; latched config, ch and k counters cleared.
- States: IDLE, SCAN, REQ, WAIT, PPU_REQ, PPU_WAIT, DONE.
- IDLE: start -> latch all cfg_*, clear err, busy=1, ch=0, k=0 -> SCAN next cycle.
- SCAN (1 cycle): priority-select lowest channel >= ch with valid bit 1 and data_len != 0. Found -> set ch, k=0, REQ. None -> PPU_REQ.
- Request sequence per selected channel:
  - df=0: input(len=data_len[ch]), then filter group k=0..K-1 (len=cfg_weight_len). Total requests = 1+K.
  - df=1: for each k: filter(k), then input. Total requests = 2K.
- REQ: req_valid=1 with fields stable until req_valid&req_ready; the handshake moves to WAIT the same edge. Fields never change while valid is held.
- WAIT: the matching finish pulse (input_finish for input requests, filter_finish for filter requests) advances to the next request (REQ next cycle). After the last request of a channel, ch=ch+1 and go to SCAN. If ch was NUM_CH-1, go to PPU_REQ.
- PPU_REQ: req_type=2, req_ch=0, req_len=0, handshake as REQ -> PPU_WAIT. ppu_finish -> DONE.
- DONE: done=1 and busy=0 for one cycle -> IDLE.
- A finish pulse not matching the outstanding request sets err and is otherwise ignored. This includes any finish pulse in IDLE, SCAN or REQ. Simultaneous matching and non-matching finishes: advance and set err.
- start while busy is ignored and does not set err.
- A mask with no eligible channels goes SCAN -> PPU_REQ directly, so only the PPU request is issued.
- Minimum latency, start to first req_valid: 2 cycles.
- Counters never wrap: k stops at K-1; ch saturates at NUM_CH-1 before PPU.
- Reset mid-operation aborts immediately to IDLE with no done pulse.

Test Plan:
- mask=3'b111, df=0, K=2, data_len={24,20,16}, weight_len=4, ready=1: 9 requests in order in(0,16),f(0,g0),f(0,g1),in(1,20),...; then PPU; done after ppu_finish; err=0.
- mask=3'b101, df=3'b100, K=2: ch0 gives in,f0,f1; ch2 gives f0,in,f1,in; ch1 never requested.
- data_len[1]=0 with mask=3'b011: ch1 skipped. K=0 behaves as K=1.
- req_ready held low 5 cycles on 2nd request: req_valid stays 1 with identical req_ch/group/len; no advance until ready.
- filter_finish pulse while waiting for input: err=1, state unchanged. Later correct input_finish advances. Next start clears err.
- rst low during WAIT of ch1: all outputs 0 asynchronously, no done. After release, a new start runs cleanly from ch0.
- mask=0, then start: the single PPU request appears 2 cycles after start; done follows ppu_finish by 1 cycle.
